// File: rtl/wb_ctrl_pipe_if.sv
// -----------------------------------------------------------------------------
// wb_ctrl_pipe_if
//   Bundles the MEM->WB instruction handshake, the HALT resume input, the
//   decoded write-back controls and the performance counters of wb_ctrl_pipe.
//
//   Parameters: OPC_W (opcode width), RA_W (register address width),
//               CNT_W (performance counter width).
//   Modports:
//     slave  - the write-back controller (wb_ctrl_pipe)
//     master - the upstream pipeline / bench driving instructions
//   Signals:
//     in_valid, in_opcode, in_rd, in_ready : instruction handshake
//     resume                               : leave HALT
//     rf_write, reg_in, regw_sel, ir4_load,
//     wr_addr, fwd_valid, stop, halted     : decoded write-back controls
//     cyc_cnt, ret_cnt                     : performance counters
// -----------------------------------------------------------------------------
interface wb_ctrl_pipe_if #(
    parameter int OPC_W = 4,
    parameter int RA_W  = 3,
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic [OPC_W-1:0] in_opcode;
    logic [RA_W-1:0]  in_rd;
    logic             in_ready;
    logic             resume;
    logic             rf_write;
    logic             reg_in;
    logic             regw_sel;
    logic             ir4_load;
    logic [RA_W-1:0]  wr_addr;
    logic             fwd_valid;
    logic             stop;
    logic             halted;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ret_cnt;

    modport slave (
        input  in_valid, in_opcode, in_rd, resume,
        output in_ready, rf_write, reg_in, regw_sel, ir4_load, wr_addr,
               fwd_valid, stop, halted, cyc_cnt, ret_cnt
    );

    modport master (
        output in_valid, in_opcode, in_rd, resume,
        input  in_ready, rf_write, reg_in, regw_sel, ir4_load, wr_addr,
               fwd_valid, stop, halted, cyc_cnt, ret_cnt
    );
endinterface

// File: rtl/wb_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// wb_ctrl_pipe
//   Write-back stage controller. Captures one instruction per accepted
//   transfer into the WB register and decodes register-file write controls
//   from it one cycle later. A STOP instruction parks the block in HALT
//   until resume is asserted.
//
//   Ports:
//     clock - sole clock, rising edge
//     reset - synchronous, active-high
//     bus   - wb_ctrl_pipe_if.slave (handshake, resume, decode outputs,
//             performance counters)
//
//   Build option: define WB_PERF_CNT_EN to build the saturating cycle and
//   retired-instruction counters; otherwise cyc_cnt/ret_cnt are tied to 0.
// -----------------------------------------------------------------------------
module wb_ctrl_pipe #(
    parameter int OPC_W   = 4,
    parameter int RA_W    = 3,
    parameter int ORI_REG = 1,
    parameter int CNT_W   = 32
) (
    input  logic            clock,
    input  logic            reset,
    wb_ctrl_pipe_if.slave   bus
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;
    localparam logic [3:0] OP_STOP = 4'd1;

    logic [0:0]      state_q, state_d;
    logic            wb_valid_q, wb_valid_d;
    logic [3:0]      wb_op_q, wb_op_d;
    logic [RA_W-1:0] wb_rd_q, wb_rd_d;
    logic [3:0]      in_op;
    logic            xfer;

    // Decode only looks at the low four opcode bits.
    logic unused_opc;
    assign unused_opc = ^bus.in_opcode;

    assign in_op        = bus.in_opcode[3:0];
    assign bus.in_ready = (state_q == ST_RUN);
    assign bus.halted   = (state_q == ST_HALT);
    assign xfer         = bus.in_valid && (state_q == ST_RUN);

    always_comb begin
        state_d    = state_q;
        wb_valid_d = xfer;
        wb_op_d    = wb_op_q;
        wb_rd_d    = wb_rd_q;
        if (xfer) begin
            wb_op_d = in_op;
            wb_rd_d = bus.in_rd;
        end
        case (state_q)
            ST_RUN:  if (xfer && in_op == OP_STOP) state_d = ST_HALT;
            // in_valid is ignored here, so resume+in_valid only returns to RUN.
            ST_HALT: if (bus.resume) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    // WB payload needs no reset: every use is qualified by wb_valid_q.
    always_ff @(posedge clock) begin
        wb_op_q <= wb_op_d;
        wb_rd_q <= wb_rd_d;
    end

    // ---- decode from WB register ----
    logic rf_write, reg_in, regw_sel, ir4_load, stop_o;

    always_comb begin
        rf_write = 1'b0;
        reg_in   = 1'b1;
        regw_sel = 1'b0;
        ir4_load = 1'b0;
        stop_o   = 1'b0;
        if (wb_valid_q) begin
            if (wb_op_q[2:0] == 3'd3) begin                    // shift
                rf_write = 1'b1; ir4_load = 1'b1; reg_in = 1'b0;
            end else if (wb_op_q[2:0] == 3'd7) begin           // ori
                rf_write = 1'b1; ir4_load = 1'b1; reg_in = 1'b0; regw_sel = 1'b1;
            end else if (wb_op_q == 4'd4 || wb_op_q == 4'd6 || wb_op_q == 4'd8) begin
                rf_write = 1'b1; ir4_load = 1'b1; reg_in = 1'b0;
            end else if (wb_op_q == 4'd0) begin                // load
                rf_write = 1'b1; ir4_load = 1'b1; reg_in = 1'b1;
            end else if (wb_op_q == OP_STOP) begin
                stop_o = 1'b1;
            end else begin
                ir4_load = 1'b1; reg_in = 1'b0;
            end
        end
    end

    assign bus.rf_write  = rf_write;
    assign bus.reg_in    = reg_in;
    assign bus.regw_sel  = regw_sel;
    assign bus.ir4_load  = ir4_load;
    assign bus.stop      = stop_o;
    assign bus.fwd_valid = rf_write;
    assign bus.wr_addr   = regw_sel ? RA_W'(ORI_REG) : wb_rd_q;

`ifdef WB_PERF_CNT_EN
    logic             started_q, started_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d;

    // The transfer that sets started is already counted as a cycle.
    always_comb begin
        started_d = started_q | xfer;
        cyc_d     = cyc_q;
        ret_d     = ret_q;
        if ((started_q || xfer) && state_q == ST_RUN && cyc_q != {CNT_W{1'b1}})
            cyc_d = cyc_q + CNT_W'(1);
        if (wb_valid_q && wb_op_q != OP_STOP && ret_q != {CNT_W{1'b1}})
            ret_d = ret_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            started_q <= 1'b0;
            cyc_q     <= '0;
            ret_q     <= '0;
        end else begin
            started_q <= started_d;
            cyc_q     <= cyc_d;
            ret_q     <= ret_d;
        end
    end

    assign bus.cyc_cnt = cyc_q;
    assign bus.ret_cnt = ret_q;
`else
    assign bus.cyc_cnt = {CNT_W{1'b0}};
    assign bus.ret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_wb_ctrl_pipe
//   Directed scoreboard bench for wb_ctrl_pipe. The driver applies one
//   vector per cycle and queues the outputs expected after the next edge;
//   a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_wb_ctrl_pipe;
    localparam int OPC_W   = 4;
    localparam int RA_W    = 3;
    localparam int ORI_REG = 1;
    localparam int CNT_W   = 3;

    logic clock = 1'b0;
    logic reset;

    wb_ctrl_pipe_if #(.OPC_W(OPC_W), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();

    wb_ctrl_pipe #(.OPC_W(OPC_W), .RA_W(RA_W), .ORI_REG(ORI_REG), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int              cyc;
        string           name;
        logic            rf, ri, rs, ir4, st, h, rdy;
        logic [RA_W-1:0] wa;
        bit              chk_cnt;
        logic [CNT_W-1:0] cc, rc;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every queued expectation that belongs to this cycle.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            bit   ok;
            e  = sb.pop_front();
            ok = (bus.rf_write == e.rf) && (bus.reg_in == e.ri) &&
                 (bus.regw_sel == e.rs) && (bus.ir4_load == e.ir4) &&
                 (bus.fwd_valid == e.rf) && (bus.stop == e.st) &&
                 (bus.halted == e.h) && (bus.in_ready == e.rdy);
            if (e.rf && bus.wr_addr != e.wa) ok = 1'b0;
            if (e.chk_cnt && (bus.cyc_cnt != e.cc || bus.ret_cnt != e.rc)) ok = 1'b0;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s: got rf=%b ri=%b rs=%b ir4=%b wa=%0d fv=%b st=%b h=%b rdy=%b cc=%0d rc=%0d; want rf=%b ri=%b rs=%b ir4=%b wa=%0d st=%b h=%b rdy=%b cc=%0d rc=%0d",
                         e.name, bus.rf_write, bus.reg_in, bus.regw_sel, bus.ir4_load,
                         bus.wr_addr, bus.fwd_valid, bus.stop, bus.halted, bus.in_ready,
                         bus.cyc_cnt, bus.ret_cnt, e.rf, e.ri, e.rs, e.ir4, e.wa,
                         e.st, e.h, e.rdy, e.cc, e.rc);
            end
        end
    end

    function automatic exp_t mk(string nm, logic rf, logic ri, logic rs, logic ir4,
                                logic [RA_W-1:0] wa, logic st, logic h, logic rdy);
        exp_t e;
        e.cyc = 0; e.name = nm;
        e.rf = rf; e.ri = ri; e.rs = rs; e.ir4 = ir4; e.wa = wa;
        e.st = st; e.h = h; e.rdy = rdy;
        e.chk_cnt = 1'b0; e.cc = '0; e.rc = '0;
        return e;
    endfunction

    function automatic exp_t idle(string nm);
        return mk(nm, 0, 1, 0, 0, '0, 0, 0, 1);
    endfunction

    function automatic exp_t halt_idle(string nm);
        return mk(nm, 0, 1, 0, 0, '0, 0, 1, 0);
    endfunction

    function automatic exp_t stp(string nm);
        return mk(nm, 0, 1, 0, 0, '0, 1, 1, 0);
    endfunction

    function automatic exp_t alu(string nm, logic [RA_W-1:0] wa);
        return mk(nm, 1, 0, 0, 1, wa, 0, 0, 1);
    endfunction

    function automatic exp_t with_cnt(exp_t e, int c, int r);
        exp_t x;
        x = e;
        x.chk_cnt = 1'b1;
`ifdef WB_PERF_CNT_EN
        x.cc = CNT_W'(c);
        x.rc = CNT_W'(r);
`else
        x.cc = '0;
        x.rc = '0;
        if (c < 0 || r < 0) x.name = {x.name, "_neg"};
`endif
        return x;
    endfunction

    task automatic step(input logic rst, input logic v, input logic [3:0] op,
                        input logic [RA_W-1:0] rd, input logic res, input exp_t e);
        exp_t x;
        @(posedge clock);
        #1;
        reset         = rst;
        bus.in_valid  = v;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.resume    = res;
        x     = e;
        x.cyc = cyc + 1;
        sb.push_back(x);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_rd     = '0;
        bus.resume    = 1'b0;

        // Reset state and reset priority over a transfer
        step(1, 0, 4'd0, 3'd0, 0, with_cnt(idle("reset"), 0, 0));
        step(1, 1, 4'd4, 3'd5, 0, idle("reset_prio"));

        // Decode of each opcode class
        step(0, 1, 4'd4, 3'd5, 0, alu("add_rd5", 3'd5));
        step(0, 0, 4'd0, 3'd0, 0, idle("add_retired"));
        step(0, 1, 4'd7, 3'd6, 0, mk("ori", 1, 0, 1, 1, 3'd1, 0, 0, 1));
        step(0, 1, 4'd0, 3'd2, 0, mk("load", 1, 1, 0, 1, 3'd2, 0, 0, 1));
        step(0, 1, 4'd10, 3'd3, 0, mk("op10", 0, 0, 0, 1, 3'd0, 0, 0, 1));
        step(0, 1, 4'd11, 3'd4, 0, alu("op11_shift", 3'd4));
        step(0, 1, 4'd8, 3'd7, 0, alu("nand", 3'd7));
        step(0, 1, 4'd15, 3'd2, 0, mk("op15_ori", 1, 0, 1, 1, 3'd1, 0, 0, 1));
        step(0, 1, 4'd6, 3'd3, 0, alu("sub", 3'd3));
        step(0, 1, 4'd9, 3'd1, 0, mk("op9", 0, 0, 0, 1, 3'd0, 0, 0, 1));
        step(0, 1, 4'd3, 3'd5, 0, alu("shift", 3'd5));

        // STOP, in_valid held through HALT, then resume
        step(0, 1, 4'd1, 3'd2, 0, stp("stop"));
        for (int i = 0; i < 5; i++)
            step(0, 1, 4'd4, 3'd5, 0, halt_idle("halt_hold"));
        step(0, 0, 4'd0, 3'd0, 1, idle("resume"));
        step(0, 0, 4'd0, 3'd0, 1, idle("resume_in_run"));

        // resume together with in_valid in HALT: no capture on that edge
        step(0, 1, 4'd1, 3'd0, 0, stp("stop2"));
        step(0, 1, 4'd4, 3'd5, 1, idle("resume_valid"));
        step(0, 0, 4'd0, 3'd0, 0, idle("no_capture"));

        // Reset mid-HALT with in_valid, and reset mid-instruction
        step(0, 1, 4'd4, 3'd6, 0, alu("add_rd6", 3'd6));
        step(0, 1, 4'd1, 3'd0, 0, stp("stop3"));
        step(1, 1, 4'd4, 3'd5, 0, idle("reset_in_halt"));
        step(0, 0, 4'd0, 3'd0, 0, idle("after_reset_halt"));
        step(0, 1, 4'd0, 3'd3, 0, mk("load2", 1, 1, 0, 1, 3'd3, 0, 0, 1));
        step(1, 1, 4'd4, 3'd2, 0, idle("reset_mid_instr"));

        // Counter stream: 10 adds after reset
        step(1, 0, 4'd0, 3'd0, 0, with_cnt(idle("cnt_reset"), 0, 0));
        for (int k = 1; k <= 10; k++) begin
            logic [RA_W-1:0] rd;
            int c, r;
            rd = k[RA_W-1:0];
            c  = (k > 7) ? 7 : k;
            r  = (k - 1 > 7) ? 7 : k - 1;
            step(0, 1, 4'd4, rd, 0, with_cnt(alu("cnt_add", rd), c, r));
        end
        step(0, 0, 4'd0, 3'd0, 0, with_cnt(idle("cnt_sat"), 7, 7));
        step(0, 1, 4'd1, 3'd0, 0, with_cnt(stp("cnt_stop"), 7, 7));
        step(0, 0, 4'd0, 3'd0, 0, with_cnt(halt_idle("cnt_hold"), 7, 7));

        repeat (3) @(posedge clock);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
